// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write path.
package regfile_pkg;

  localparam int RF_ADDR_W    = 8;
  localparam int RF_DATA_W    = 32;
  localparam int RF_DEPTH     = 1 << RF_ADDR_W;
  localparam int RF_ZERO_ADDR = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_e;

endpackage

// File: rtl/regfile_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  // N is a power of two, so the index addition wraps by truncation.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        any       = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Write-port controller: zero-fills the register file, then round-robins the
// single write port between NUM_REQ valid/ready requesters.
module regfile_write_sequencer
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_req,
  output logic                         busy,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_addr_wr,
  output logic [DATA_W-1:0]            rf_data_in,
  output logic [$clog2(NUM_REQ)-1:0]   last_grant
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(RF_ZERO_ADDR);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;

  logic [ADDR_W-1:0] addr_slice [NUM_REQ];
  logic [DATA_W-1:0] data_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_slice[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_slice[g] = req_data[g*DATA_W +: DATA_W];
  end

  // A pending clear pulse masks every grant in the cycle it is seen.
  assign arb_req = (state_q == ST_RUN && !clear_req) ? req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign req_ready  = gnt;
  assign busy       = (state_q == ST_CLEAR);
  assign rf_we      = rf_we_q;
  assign rf_addr_wr = rf_addr_q;
  assign rf_data_in = rf_data_q;
  assign last_grant = last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= ADDR_ONE;
      rr_ptr_q     <= '0;
      last_grant_q <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == ADDR_LAST) begin
          state_d    = ST_RUN;
          clr_addr_d = ADDR_ONE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = ADDR_ONE;
      end
    endcase
  end

  // Address-0 requests are accepted but never raise the write enable.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_CLEAR: begin
        rf_we_d   = 1'b1;
        rf_addr_d = clr_addr_q;
        rf_data_d = '0;
      end
      ST_RUN: begin
        if (gnt_any) begin
          rf_addr_d    = addr_slice[gnt_idx];
          rf_data_d    = data_slice[gnt_idx];
          rf_we_d      = (addr_slice[gnt_idx] != ADDR_ZERO);
          rr_ptr_d     = gnt_idx + IDX_ONE;
          last_grant_d = gnt_idx;
        end else begin
          rf_we_d = 1'b0;
        end
      end
      default: begin
        rf_we_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer with a behavioural register-file model.
module tb_regfile_write_sequencer;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      clear_req;
  logic                      busy;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_addr_wr;
  logic [DATA_W-1:0]         rf_data_in;
  logic [1:0]                last_grant;

  logic [DATA_W-1:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_sequencer #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_we      (rf_we),
    .rf_addr_wr (rf_addr_wr),
    .rf_data_in (rf_data_in),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  // Raw storage: any write that reaches it, including address 0, is visible.
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr_wr] <= rf_data_in;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [31:0] d);
    req_addr[idx*ADDR_W +: ADDR_W] = a;
    req_data[idx*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_fill(input string tag, input bit pulse_mid);
    int bad;
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      clear_req = pulse_mid && (i == 50);
      if (rf_we !== 1'b1 || rf_addr_wr !== i[7:0] || rf_data_in !== 32'h0) bad++;
      if (busy !== (i != 255)) bad++;
      if (i != 255 && req_ready !== 4'b0000) bad++;
    end
    clear_req = 1'b0;
    check_eq({tag, "_seq"}, 64'(bad), 64'd0);
    check_eq({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int order [5];
    int cyc;
    order = '{0, 1, 2, 3, 0};
    for (int a = 0; a < 256; a++) mem[a] = (a == 0) ? 32'h0 : 32'hDEAD_BEEF;
    rst = 1'b1;
    clear_req = 1'b0;
    req_valid = 4'hF;
    req_addr = '0;
    req_data = '0;
    #2;
    check_eq("rst_busy", 64'(busy), 64'd1);
    check_eq("rst_we", 64'(rf_we), 64'd0);
    check_eq("rst_addr", 64'(rf_addr_wr), 64'd0);
    check_eq("rst_data", 64'(rf_data_in), 64'd0);
    check_eq("rst_lg", 64'(last_grant), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);

    // 1: zero-fill after reset release
    step();
    rst = 1'b0;
    do_fill("fill1", 1'b0);
    req_valid = 4'h0;
    step();
    check_eq("post_fill_we", 64'(rf_we), 64'd0);
    check_eq("post_fill_addr_hold", 64'(rf_addr_wr), 64'd255);
    check_eq("mem200_zero", 64'(mem[200]), 64'd0);

    // 2: requester 2 writes addr 1
    set_req(2, 8'd1, 32'hA5A5_A5A5);
    req_valid = 4'b0100;
    #1;
    check_eq("t2_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = 4'b0000;
    check_eq("t2_we", 64'(rf_we), 64'd1);
    check_eq("t2_addr", 64'(rf_addr_wr), 64'd1);
    check_eq("t2_data", 64'(rf_data_in), 64'hA5A5_A5A5);
    check_eq("t2_lg", 64'(last_grant), 64'd2);
    step();
    check_eq("t2_we_drop", 64'(rf_we), 64'd0);
    check_eq("t2_mem1", 64'(mem[1]), 64'hA5A5_A5A5);

    // requester 3 alone moves the pointer to 0
    set_req(3, 8'd2, 32'h0000_0033);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    check_eq("t3pre_lg", 64'(last_grant), 64'd3);

    // 3: all four valid, rotation 0,1,2,3,0
    for (int r = 0; r < 4; r++) set_req(r, 8'(10 + r), 32'h1000_0000 + 32'(r));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("t3_ready%0d", k), 64'(req_ready), 64'(4'b0001 << order[k]));
      step();
      check_eq($sformatf("t3_we%0d", k), 64'(rf_we), 64'd1);
      check_eq($sformatf("t3_addr%0d", k), 64'(rf_addr_wr), 64'(10 + order[k]));
      check_eq($sformatf("t3_data%0d", k), 64'(rf_data_in), 64'(32'h1000_0000 + 32'(order[k])));
      check_eq($sformatf("t3_lg%0d", k), 64'(last_grant), 64'(order[k]));
    end
    req_valid = 4'h0;

    // 4: address-0 request from requester 1 (pointer now 1)
    set_req(1, 8'd0, 32'hFFFF_FFFF);
    req_valid = 4'b0010;
    #1;
    check_eq("t4_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid = 4'b0000;
    check_eq("t4_we", 64'(rf_we), 64'd0);
    check_eq("t4_addr", 64'(rf_addr_wr), 64'd0);
    check_eq("t4_data", 64'(rf_data_in), 64'hFFFF_FFFF);
    check_eq("t4_lg", 64'(last_grant), 64'd1);
    step();
    check_eq("t4_mem0", 64'(mem[0]), 64'd0);

    // 5: clear while requester 1 waits; mid-fill pulse must not restart
    set_req(1, 8'd1, 32'h5A5A_5A5A);
    req_valid = 4'b0010;
    clear_req = 1'b1;
    #1;
    check_eq("t5_ready_masked", 64'(req_ready), 64'd0);
    step();
    clear_req = 1'b0;
    check_eq("t5_busy", 64'(busy), 64'd1);
    check_eq("t5_we", 64'(rf_we), 64'd0);
    do_fill("fill2", 1'b1);
    check_eq("t5_ready_at_fall", 64'(req_ready), 64'b0010);
    check_eq("t5_mem1_cleared", 64'(mem[1]), 64'd0);
    step();
    req_valid = 4'b0000;
    check_eq("t5_we", 64'(rf_we), 64'd1);
    check_eq("t5_addr", 64'(rf_addr_wr), 64'd1);
    check_eq("t5_data", 64'(rf_data_in), 64'h5A5A_5A5A);
    check_eq("t5_lg", 64'(last_grant), 64'd1);
    step();
    check_eq("t5_mem1", 64'(mem[1]), 64'h5A5A_5A5A);

    // 6: asynchronous reset in the middle of a fill
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    cyc = 0;
    while (rf_addr_wr !== 8'd100 && cyc < 300) begin
      step();
      cyc++;
    end
    check_eq("t6_reach100", 64'(rf_addr_wr), 64'd100);
    rst = 1'b1;
    #1;
    check_eq("t6_we", 64'(rf_we), 64'd0);
    check_eq("t6_addr", 64'(rf_addr_wr), 64'd0);
    check_eq("t6_lg", 64'(last_grant), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd1);
    step();
    rst = 1'b0;
    do_fill("fill3", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_sequencer.md
# regfile_write_sequencer

Write-port controller for the 3-port register file (two read ports, one write port, register 0 hardwired to zero). Sits directly in front of the register file's `addr_wr`/`data_in`/`we` inputs. After reset it zero-fills every writable register. It then shares the single write port between `NUM_REQ` requesters using round-robin arbitration with a valid/ready handshake. A software-style `clear_req` re-runs the zero-fill at any time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of write requesters (power of two, ≥2).
- `ADDR_W`, 8: register address width; depth = 2^ADDR_W.
- `DATA_W`, 32: register data width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `clear_req` in 1: single-cycle pulse requesting a zero-fill.
- `busy` out 1: high while zero-fill is in progress.
- `req_valid` in NUM_REQ: per-requester write request.
- `req_ready` out NUM_REQ: per-requester grant; one-hot or zero.
- `req_addr` in NUM_REQ*ADDR_W: packed; slice i belongs to requester i.
- `req_data` in NUM_REQ*DATA_W: packed; slice i belongs to requester i.
- `rf_we` out 1: to register file `we`.
- `rf_addr_wr` out ADDR_W: to register file `addr_wr`.
- `rf_data_in` out DATA_W: to register file `data_in`.
- `last_grant` out clog2(NUM_REQ): index of the most recent accepted requester.

## Operation
- Two states: CLEAR and RUN. `busy` = (state == CLEAR).
- Reset values: state CLEAR, `clr_addr` = 1, `rr_ptr` = 0, `rf_we` = 0, `rf_addr_wr` = 0, `rf_data_in` = 0, `last_grant` = 0. `req_ready` is all 0 because the state is CLEAR.
- CLEAR:
  - Each edge registers `rf_we` = 1, `rf_addr_wr` = `clr_addr`, `rf_data_in` = 0, then increments `clr_addr`.
  - Address 0 is never written.
  - On the edge that registers address 2^ADDR_W−1: state → RUN and `clr_addr` → 1.
  - `clear_req` is ignored in CLEAR; it does not restart the sequence.
- RUN, arbitration:
  - Combinational round-robin over `req_valid`. Search starts at `rr_ptr` and wraps.
  - The winner gets `req_ready[i]` = 1.
  - Transfer happens when `req_valid[i]` && `req_ready[i]`.
- RUN, on a transfer edge:
  - `rf_addr_wr`/`rf_data_in` ← winner's slices.
  - `rf_we` ← 1, unless the address is 0. An address-0 request is accepted (ready high) but `rf_we` stays 0.
  - `rr_ptr` ← winner+1 mod NUM_REQ; `last_grant` ← winner.
- RUN with no transfer: `rf_we` ← 0; `rf_addr_wr`/`rf_data_in` hold.
- `clear_req` high in RUN: all `req_ready` forced 0 that cycle, and the next edge enters CLEAR. `rr_ptr` is preserved.
- Requester rule: once `req_valid` rises, addr/data stay stable and valid stays high until the transfer. The sequencer does not check this.

## Timing
- Write latency: transfer edge → `rf_we`/addr/data valid on the register-file inputs during the following cycle. The RAM commits at the next edge.
- Throughput: one write per cycle in RUN. A requester that stays valid is served at least once every NUM_REQ cycles.
- Zero-fill: exactly 2^ADDR_W−1 consecutive `rf_we` cycles (255 at defaults).
  - `busy` falls on the edge that registers the last clear write.
  - The first grant can occur in that same cycle, and its write lands on the following cycle.
- Back-to-back: CLEAR writes and RUN writes are contiguous, with no bubble.
- `rst` mid-operation clears all state immediately (asynchronous). The zero-fill restarts from address 1 after release.

## Structure
- Shared package `regfile_pkg` holds:
  - `ADDR_W`, `DATA_W` defaults and `RF_DEPTH`.
  - `RF_ZERO_ADDR` = 0.
  - the state encoding (CLEAR = 0, RUN = 1).
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`; outputs one-hot `gnt`, `gnt_idx`, `any`. It is purely combinational.
- Top level: the FSM, `clr_addr` counter, `rr_ptr` register, output registers and slice muxes.

## Test plan
1. Release `rst` → `busy` = 1 for 255 cycles; `rf_we` = 1 with `rf_addr_wr` = 1..255 and data 0; `req_ready` = 0 throughout; `busy` then 0.
2. After the fill, requester 2 writes addr 1, data A5A5A5A5 → `rf_we`/`rf_addr_wr` = 1/`rf_data_in` = A5A5A5A5 on the next cycle. The register file's port A then reads A5A5A5A5.
3. All four requesters held valid with distinct addresses → grant order 0, 1, 2, 3, 0 on consecutive cycles. `last_grant` tracks it, and `rf_we` stays high continuously.
4. Request to addr 0 with data FFFFFFFF → ready = 1 and accepted. `rf_we` stays 0, and both read ports at addr 0 return 00000000.
5. `clear_req` pulse while requester 1 is valid → `req_ready` = 0 that cycle, then 255 clear writes. Requester 1 is granted on the cycle `busy` falls, and addr 1 reads A5A5A5A5 again only if rewritten.
6. Assert `rst` when `rf_addr_wr` = 100 during the fill → all outputs go to 0 immediately. After release the fill restarts at addr 1 and runs the full 255 cycles.
